// File: rtl/pwm_cuatro_bits_if.sv
// ============================================================================
// pwm_cuatro_bits_if : duty/run-control bus between the 8-to-4 stage and PWM
// Rev 1.0
// ============================================================================
`default_nettype none

interface pwm_cuatro_bits_if;
  logic       enable;
  logic [3:0] duty_in;
  logic       pwm_out;
  logic [3:0] duty_active;
  logic       period_start;

  modport master (
    output enable,
    output duty_in,
    input  pwm_out,
    input  duty_active,
    input  period_start
  );

  modport slave (
    input  enable,
    input  duty_in,
    output pwm_out,
    output duty_active,
    output period_start
  );
endinterface

`default_nettype wire

// File: rtl/pwm_cuatro_bits.sv
// ============================================================================
// pwm_cuatro_bits : 16-level PWM, 15-step period, double-buffered duty
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_cuatro_bits #(
  parameter int PRESCALE = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_cuatro_bits_if.slave  bus
);

  localparam int          c_pre_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(PRESCALE - 1);
  localparam logic [3:0]  c_step_max = 4'd14;

  logic [c_pre_w-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]         step_cnt_q, step_cnt_d;
  logic [3:0]         duty_active_q, duty_active_d;
  logic               run_q, run_d;
  logic               period_start_q, period_start_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q      <= '0;
      step_cnt_q     <= '0;
      duty_active_q  <= '0;
      run_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      step_cnt_q     <= step_cnt_d;
      duty_active_q  <= duty_active_d;
      run_q          <= run_d;
      period_start_q <= period_start_d;
    end
  end

  always_comb begin
    pre_cnt_d      = pre_cnt_q;
    step_cnt_d     = step_cnt_q;
    duty_active_d  = duty_active_q;
    run_d          = run_q;
    period_start_d = 1'b0;

    if (!bus.enable) begin
      // Idle: shadow register follows the request so a restart uses fresh duty
      pre_cnt_d     = '0;
      step_cnt_d    = '0;
      duty_active_d = bus.duty_in;
      run_d         = 1'b0;
    end else if (!run_q) begin
      run_d          = 1'b1;
      period_start_d = 1'b1;
    end else if (pre_cnt_q != c_pre_max) begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end else begin
      pre_cnt_d = '0;
      if (step_cnt_q != c_step_max) begin
        step_cnt_d = step_cnt_q + 4'd1;
      end else begin
        step_cnt_d     = '0;
        duty_active_d  = bus.duty_in;
        period_start_d = 1'b1;
      end
    end
  end

  // step_cnt never reaches 15, so duty 15 yields a constant high output
  assign bus.pwm_out      = run_q & (step_cnt_q < duty_active_q);
  assign bus.duty_active  = duty_active_q;
  assign bus.period_start = period_start_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_cuatro_bits.sv
// ============================================================================
// tb_pwm_cuatro_bits : scoreboard bench, one DUT at PRESCALE=4, one at 1
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pwm_cuatro_bits;

  typedef struct {
    int duty;
    int high;
    int len;   // 0 = period left open at end of run, only duty is checked
  } rec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   p;

  rec_t qa[$];
  rec_t qb[$];

  pwm_cuatro_bits_if ifa ();
  pwm_cuatro_bits_if ifb ();

  pwm_cuatro_bits #(.PRESCALE(4)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  pwm_cuatro_bits #(.PRESCALE(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int d, input int h, input int l);
    rec_t r;
    r.duty = d;
    r.high = h;
    r.len  = l;
    return r;
  endfunction

  task automatic goto(input int target);
    repeat (target - p) @(posedge clk);
    #1;
    p = target;
  endtask

  // Monitor: each period_start closes the previous period and opens the next
  int   m_open [2];
  int   m_len  [2];
  int   m_high [2];
  rec_t m_cur  [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_open[i] = 0;
      m_len[i]  = 0;
      m_high[i] = 0;
    end
  end

  always @(negedge clk) begin
    logic       ps [2];
    logic       pw [2];
    logic [3:0] da [2];
    ps[0] = ifa.period_start; pw[0] = ifa.pwm_out; da[0] = ifa.duty_active;
    ps[1] = ifb.period_start; pw[1] = ifb.pwm_out; da[1] = ifb.duty_active;
    for (int i = 0; i < 2; i++) begin
      if (rst_n && ps[i] === 1'b1) begin
        if (m_open[i] != 0) begin
          chk($sformatf("dut%0d period_len", i), m_len[i], m_cur[i].len);
          chk($sformatf("dut%0d high_cycles", i), m_high[i], m_cur[i].high);
        end
        if ((i == 0 && qa.size() == 0) || (i == 1 && qb.size() == 0)) begin
          chk($sformatf("dut%0d unexpected_period_start", i), 1, 0);
          m_open[i] = 0;
        end else begin
          m_cur[i]  = (i == 0) ? qa.pop_front() : qb.pop_front();
          m_open[i] = 1;
          chk($sformatf("dut%0d duty_active", i), int'(da[i]), m_cur[i].duty);
        end
        m_len[i]  = 0;
        m_high[i] = 0;
      end
      if (m_open[i] != 0) begin
        m_len[i]++;
        if (pw[i] === 1'b1) m_high[i]++;
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    p     = 0;
    rst_n = 1'b0;
    ifa.enable  = 1'b1;
    ifa.duty_in = 4'd9;
    ifb.enable  = 1'b0;
    ifb.duty_in = 4'd7;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst pwm_a",  int'(ifa.pwm_out),      0);
      chk("rst ps_a",   int'(ifa.period_start), 0);
      chk("rst duty_a", int'(ifa.duty_active),  0);
      chk("rst pwm_b",  int'(ifb.pwm_out),      0);
      chk("rst ps_b",   int'(ifb.period_start), 0);
      chk("rst duty_b", int'(ifb.duty_active),  0);
    end

    // First period after release runs the reset duty (0); 5 lands at the wrap
    qa.push_back(mk(0, 0, 60));
    qa.push_back(mk(5, 20, 60));
    qa.push_back(mk(5, 20, 60));
    rst_n       = 1'b1;
    ifa.duty_in = 4'd5;
    @(posedge clk);
    #1;
    p = 0;

    goto(130); ifa.duty_in = 4'd0;  qa.push_back(mk(0, 0, 60));
    goto(190); ifa.duty_in = 4'd15; qa.push_back(mk(15, 60, 60));
    goto(250); ifa.duty_in = 4'd3;  qa.push_back(mk(3, 12, 60));
    goto(325); ifa.duty_in = 4'd12; qa.push_back(mk(12, 48, 60));
    goto(370); ifa.duty_in = 4'd8;  qa.push_back(mk(8, 10, 15));

    goto(429);
    ifa.enable  = 1'b0;
    ifa.duty_in = 4'd2;
    qa.push_back(mk(2, 8, 60));
    goto(430);
    @(negedge clk);
    chk("drop pwm_a", int'(ifa.pwm_out),      0);
    chk("drop ps_a",  int'(ifa.period_start), 0);

    goto(434); ifa.enable = 1'b1; qa.push_back(mk(2, 0, 0));
    goto(500); ifa.enable = 1'b0;

    // PRESCALE=1: two full periods, then enable falls on the wrap edge
    goto(510);
    qb.push_back(mk(7, 7, 15));
    qb.push_back(mk(7, 7, 18));
    qb.push_back(mk(4, 4, 15));
    qb.push_back(mk(4, 0, 0));
    ifb.enable = 1'b1;

    goto(540);
    ifb.enable  = 1'b0;
    ifb.duty_in = 4'd4;
    goto(541);
    @(negedge clk);
    chk("wrap_drop ps_b",   int'(ifb.period_start), 0);
    chk("wrap_drop pwm_b",  int'(ifb.pwm_out),      0);
    chk("wrap_drop duty_b", int'(ifb.duty_active),  4);

    goto(543); ifb.enable = 1'b1;
    goto(570);
    @(negedge clk);

    chk("dut0 pending_records", qa.size(), 0);
    chk("dut1 pending_records", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
